// File: rtl/mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_responder_pkg
//   Shared encodings for the memory responder: data-type (DT) codes, R_W
//   polarity, FSM state encoding, the four-byte lane bundle type and the
//   alignment rule used by the byte-lane logic.
// -----------------------------------------------------------------------------
package mem_responder_pkg;

  // Data type codes driven by the control unit on DT. Code 2'b11 is also a
  // word access; it falls through to the word case wherever DT is decoded.
  localparam logic [1:0] DT_BYTE = 2'b00;
  localparam logic [1:0] DT_HALF = 2'b01;
  localparam logic [1:0] DT_WORD = 2'b10;

  // R_W polarity.
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // The wait-state counter covers WAIT_CYCLES in the range 0..15.
  localparam int CNT_BITS = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Byte k of the bundle corresponds to memory location A+k, where A is the
  // request address. Big-endian order puts the most significant byte at A.
  typedef logic [3:0][7:0] lane_bytes_t;

  // Halfwords must start on an even address; words must start on a multiple of
  // four. Bytes are always aligned.
  function automatic logic is_aligned(input logic [1:0] dt, input logic [1:0] addr_lo);
    case (dt)
      DT_BYTE: return 1'b1;
      DT_HALF: return ~addr_lo[0];
      default: return (addr_lo == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// -----------------------------------------------------------------------------
// mem_responder_if
//   Memory handshake between the control unit / datapath (master) and the
//   memory responder (slave).
//     MOV       master->slave  memory operation valid, held until MOC is seen
//     R_W       master->slave  1 = read, 0 = write
//     DT        master->slave  data type: 00 byte, 01 halfword, 1x word
//     addr      master->slave  byte address from MAR
//     data_in   master->slave  write data from MDR, right-justified
//     data_out  slave->master  read data to MDR, right-justified, zero-extended
//     MOC       slave->master  memory operation complete
//     align_err slave->master  misaligned access flag, valid while MOC=1
// -----------------------------------------------------------------------------
interface mem_responder_if;

  logic        MOV;
  logic        R_W;
  logic [1:0]  DT;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        MOC;
  logic        align_err;

  modport master (
    output MOV, R_W, DT, addr, data_in,
    input  data_out, MOC, align_err
  );

  modport slave (
    input  MOV, R_W, DT, addr, data_in,
    output data_out, MOC, align_err
  );

endinterface

// File: rtl/mem_byte_lane.sv
// -----------------------------------------------------------------------------
// mem_byte_lane
//   Combinational big-endian byte steering for the memory responder.
//   Ports:
//     dt_i       data type code of the access
//     addr_lo_i  low two address bits, used for the alignment check
//     wdata_i    right-justified write data
//     rbytes_i   bytes currently stored at A, A+1, A+2, A+3
//     rdata_o    right-justified, zero-extended read data
//     wbytes_o   bytes to store at A, A+1, A+2, A+3
//     wen_o      per-byte write enables for A..A+3 (bit k -> A+k)
//     aligned_o  1 when the access is naturally aligned
// -----------------------------------------------------------------------------
module mem_byte_lane
  import mem_responder_pkg::*;
(
  input  logic [1:0]  dt_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  lane_bytes_t rbytes_i,
  output logic [31:0] rdata_o,
  output lane_bytes_t wbytes_o,
  output logic [3:0]  wen_o,
  output logic        aligned_o
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves one unassigned, which would infer a latch.
    rdata_o   = '0;
    wbytes_o  = '0;
    wen_o     = '0;
    aligned_o = is_aligned(dt_i, addr_lo_i);

    case (dt_i)
      DT_BYTE: begin
        rdata_o     = {24'h0, rbytes_i[0]};
        wbytes_o[0] = wdata_i[7:0];
        wen_o       = 4'b0001;
      end
      DT_HALF: begin
        rdata_o     = {16'h0, rbytes_i[0], rbytes_i[1]};
        wbytes_o[0] = wdata_i[15:8];
        wbytes_o[1] = wdata_i[7:0];
        wen_o       = 4'b0011;
      end
      default: begin
        rdata_o     = {rbytes_i[0], rbytes_i[1], rbytes_i[2], rbytes_i[3]};
        wbytes_o[0] = wdata_i[31:24];
        wbytes_o[1] = wdata_i[23:16];
        wbytes_o[2] = wdata_i[15:8];
        wbytes_o[3] = wdata_i[7:0];
        wen_o       = 4'b1111;
      end
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Byte-addressed, big-endian RAM that answers the control unit's
//   MOV/R_W/DT/MOC handshake. A request is latched in IDLE, held for
//   WAIT_CYCLES in BUSY, performed on the last BUSY cycle, and acknowledged
//   with MOC in DONE until MOV is released.
//   Parameters:
//     DEPTH        memory size in bytes (power of two)
//     ADDR_BITS    log2(DEPTH); higher address bits are ignored (wrap)
//     WAIT_CYCLES  extra cycles between acceptance and MOC (0..15)
//   Ports:
//     clk  rising-edge clock
//     clr  synchronous reset, active-low
//     bus  slave side of the memory handshake
// -----------------------------------------------------------------------------
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic           clk,
  input  logic           clr,
  mem_responder_if.slave bus
);

  // ---------------------------------------------------------------------------
  // State and request registers
  // ---------------------------------------------------------------------------
  state_e                state_q;
  logic [CNT_BITS-1:0]   cnt_q;
  logic [ADDR_BITS-1:0]  addr_q;
  logic [1:0]            dt_q;
  logic                  rw_q;
  logic [31:0]           wdata_q;
  logic [31:0]           data_out_q;
  logic                  moc_q;
  logic                  align_err_q;

  logic [7:0]            mem_q [DEPTH];

  // Address bits above ADDR_BITS are deliberately ignored so accesses wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.addr[31:ADDR_BITS];

  // ---------------------------------------------------------------------------
  // Byte steering for the latched request
  // ---------------------------------------------------------------------------
  logic [ADDR_BITS-1:0]  idx_d [4];
  lane_bytes_t           rbytes_d;
  lane_bytes_t           wbytes_d;
  logic [31:0]           rdata_d;
  logic [3:0]            wen_d;
  logic                  aligned_d;
  logic                  access_d;
  logic                  mem_we_d;

  // Locations A..A+3 wrap modulo DEPTH through the ADDR_BITS-wide sum.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      idx_d[k]    = addr_q + ADDR_BITS'(k);
      rbytes_d[k] = mem_q[idx_d[k]];
    end
  end

  mem_byte_lane u_lane (
    .dt_i      (dt_q),
    .addr_lo_i (addr_q[1:0]),
    .wdata_i   (wdata_q),
    .rbytes_i  (rbytes_d),
    .rdata_o   (rdata_d),
    .wbytes_o  (wbytes_d),
    .wen_o     (wen_d),
    .aligned_o (aligned_d)
  );

  // The access happens on the last BUSY cycle. A reset on that same edge wins,
  // so an aborted write never reaches the array.
  assign access_d = (state_q == ST_BUSY) && (cnt_q == '0);
  assign mem_we_d = clr && access_d && (rw_q == RW_WRITE) && aligned_d;

  // ---------------------------------------------------------------------------
  // Storage array
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset branch; contents survive clr, and leaving it
  // out lets the array map onto RAM rather than thousands of reset flops.
  always_ff @(posedge clk) begin
    if (mem_we_d) begin
      for (int k = 0; k < 4; k++) begin
        if (wen_d[k]) begin
          mem_q[idx_d[k]] <= wbytes_d[k];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake FSM with registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      dt_q        <= DT_BYTE;
      rw_q        <= RW_READ;
      wdata_q     <= '0;
      data_out_q  <= '0;
      moc_q       <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.MOV) begin
            addr_q  <= bus.addr[ADDR_BITS-1:0];
            dt_q    <= bus.DT;
            rw_q    <= bus.R_W;
            wdata_q <= bus.data_in;
            cnt_q   <= CNT_BITS'(WAIT_CYCLES);
            state_q <= ST_BUSY;
          end
        end

        ST_BUSY: begin
          // MOV is not consulted here: once accepted, the access always
          // completes, and DONE handles an early release.
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            moc_q   <= 1'b1;
            state_q <= ST_DONE;
            if (!aligned_d) begin
              data_out_q  <= '0;
              align_err_q <= 1'b1;
            end else if (rw_q == RW_READ) begin
              data_out_q <= rdata_d;
            end
          end
        end

        ST_DONE: begin
          // data_out keeps its value after release; only the flags drop.
          if (!bus.MOV) begin
            moc_q       <= 1'b0;
            align_err_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.MOC       = moc_q;
  assign bus.align_err = align_err_q;

endmodule
